avg_pooling_layer: RTL and testbench

- 2x2, stride-2 average pooling over a 28x28 signed 8-bit image, producing a 14x14 signed 16-bit map.
- Sits after the convolution/activation stage of the inference pipeline.
- Computes one output per clock, in row-major order, while enabled.
- Raises a done flag when all 196 outputs are written.

---
 rtl/avg_pooling_layer.sv | 98 +++++++++
 tb/tb_avg_pooling_layer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/avg_pooling_layer.sv
// 2x2 stride-2 average pooling: one pooled element per enabled clock, row-major,
// into a fully registered output map, with a finished flag after the last element.
module avg_pooling_layer #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] img  [0:IMG_W*IMG_H-1],
  output logic signed [OUT_W-1:0]  pool [0:(IMG_W/2)*(IMG_H/2)-1],
  output logic                     finished_pool
);

  localparam int OW      = IMG_W / 2;
  localparam int OH      = IMG_H / 2;
  localparam int N_OUT   = OW * OH;
  localparam int IDX_W   = $clog2(IMG_W * IMG_H);
  localparam int OIDX_W  = $clog2(N_OUT);
  localparam int ROW_W   = $clog2(OH);
  localparam int COL_W   = $clog2(OW);
  localparam int SUM_W   = DATA_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q;
  logic [ROW_W-1:0]         i_q;
  logic [COL_W-1:0]         j_q;
  logic                     finished_q;
  logic signed [OUT_W-1:0]  pool_q [0:N_OUT-1];

  logic [IDX_W-1:0]         base_d;
  logic [OIDX_W-1:0]        out_idx_d;
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [OUT_W-1:0]  avg_d;

  // Top-left pixel of the current 2x2 window and the matching output slot.
  always_comb begin
    base_d    = IDX_W'(2 * IMG_W) * IDX_W'(i_q) + IDX_W'(2) * IDX_W'(j_q);
    out_idx_d = OIDX_W'(OW) * OIDX_W'(i_q) + OIDX_W'(j_q);
    sum_d     = SUM_W'(img[base_d])
              + SUM_W'(img[base_d + IDX_W'(1)])
              + SUM_W'(img[base_d + IDX_W'(IMG_W)])
              + SUM_W'(img[base_d + IDX_W'(IMG_W + 1)]);
    avg_d     = OUT_W'(sum_d >>> 2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      finished_q <= 1'b0;
      for (int k = 0; k < N_OUT; k++) pool_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= RUN;
            i_q     <= '0;
            j_q     <= '0;
          end
        end
        RUN: begin
          if (enable) begin
            pool_q[out_idx_d] <= avg_d;
            if (j_q == COL_W'(OW - 1)) begin
              j_q <= '0;
              if (i_q == ROW_W'(OH - 1)) begin
                i_q        <= '0;
                state_q    <= DONE;
                finished_q <= 1'b1;
              end else begin
                i_q <= i_q + ROW_W'(1);
              end
            end else begin
              j_q <= j_q + COL_W'(1);
            end
          end
        end
        DONE: begin
          // Results stay in place; only the flag drops on the way back to IDLE.
          if (!enable) begin
            state_q    <= IDLE;
            finished_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pool          = pool_q;
  assign finished_pool = finished_q;

endmodule

// File: tb/tb_avg_pooling_layer.sv
// Randomized bench for avg_pooling_layer against a floor-division model of 2x2 pooling.
module tb_avg_pooling_layer;

  localparam int W = 28;
  localparam int H = 28;
  localparam int OW = W / 2;
  localparam int OH = H / 2;
  localparam int N_IN = W * H;
  localparam int N_OUT = OW * OH;

  logic                    clk;
  logic                    reset;
  logic                    enable;
  logic signed [7:0]       img  [0:N_IN-1];
  logic signed [15:0]      pool [0:N_OUT-1];
  logic                    finished_pool;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_pool [0:N_OUT-1];
  int edges;

  avg_pooling_layer #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .OUT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .img          (img),
    .pool         (pool),
    .finished_pool(finished_pool)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Floor of s/4 written as plain integer arithmetic.
  function automatic int floor_div4(input int s);
    if (s >= 0) return s / 4;
    return -((-s + 3) / 4);
  endfunction

  task automatic build_model();
    for (int i = 0; i < OH; i++)
      for (int j = 0; j < OW; j++) begin
        int s;
        s = int'(img[(2*i)*W + 2*j]) + int'(img[(2*i)*W + 2*j + 1])
          + int'(img[(2*i+1)*W + 2*j]) + int'(img[(2*i+1)*W + 2*j + 1]);
        exp_pool[i*OW + j] = floor_div4(s);
      end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < N_OUT; k++)
      check($sformatf("%s pool[%0d]", tag, k), int'(pool[k]), exp_pool[k]);
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < N_OUT; k++)
      check($sformatf("%s pool[%0d]", tag, k), int'(pool[k]), 0);
  endtask

  task automatic fill_random();
    for (int k = 0; k < N_IN; k++) img[k] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill_const(input int v);
    for (int k = 0; k < N_IN; k++) img[k] = 8'(v);
  endtask

  task automatic set_block(input int i, input int j, input int a, input int b,
                           input int c, input int d);
    img[(2*i)*W + 2*j]       = 8'(a);
    img[(2*i)*W + 2*j + 1]   = 8'(b);
    img[(2*i+1)*W + 2*j]     = 8'(c);
    img[(2*i+1)*W + 2*j + 1] = 8'(d);
  endtask

  // Starts from IDLE; returns edges after the IDLE->RUN edge until finished_pool.
  task automatic run_pass(input int pause_after, input int pause_len, output int n);
    enable = 1'b1;
    tick();
    n = 0;
    while (!finished_pool && n < 400) begin
      if (pause_len > 0 && n == pause_after) begin
        enable = 1'b0;
        repeat (pause_len) begin
          tick();
          n++;
        end
        check("pause_no_finish", int'(finished_pool), 0);
        enable = 1'b1;
      end
      tick();
      n++;
    end
  endtask

  task automatic leave_done(input string tag);
    enable = 1'b0;
    tick();
    check({tag, " finished_clr"}, int'(finished_pool), 0);
    check_all({tag, " retained"});
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    fill_random();
    repeat (3) tick();
    check("reset finished", int'(finished_pool), 0);
    check_zero("reset");
    reset = 1'b1;
    tick();

    // Digit-style image with a lone 8 in the first block.
    fill_random();
    set_block(0, 0, 8, 0, 0, 0);
    build_model();
    run_pass(0, 0, edges);
    check("first latency", edges, 196);
    check("first pool0", int'(pool[0]), 2);
    check_all("first");
    leave_done("first");

    fill_const(127);
    build_model();
    run_pass(0, 0, edges);
    check("max latency", edges, 196);
    check("max pool0", int'(pool[0]), 127);
    check_all("max");
    leave_done("max");

    fill_const(-128);
    build_model();
    run_pass(0, 0, edges);
    check("min latency", edges, 196);
    check("min pool195", int'(pool[195]), -128);
    check_all("min");
    leave_done("min");

    fill_random();
    set_block(0, 0, -1, 0, 0, 0);
    set_block(0, 1, 1, 1, 1, 0);
    set_block(0, 2, -3, -3, -3, -3);
    set_block(0, 3, 5, 6, 7, 8);
    build_model();
    run_pass(0, 0, edges);
    check("round latency", edges, 196);
    check("round neg1", int'(pool[0]), -1);
    check("round 3of4", int'(pool[1]), 0);
    check("round neg3", int'(pool[2]), -3);
    check("round 5678", int'(pool[3]), 6);
    check_all("round");
    leave_done("round");

    fill_random();
    build_model();
    run_pass(50, 20, edges);
    check("pause latency", edges, 216);
    check_all("pause");
    leave_done("pause");

    // Reset in the middle of a pass, then a clean full pass.
    fill_random();
    build_model();
    enable = 1'b1;
    tick();
    repeat (100) tick();
    check("midrun not_done", int'(finished_pool), 0);
    reset = 1'b0;
    #1;
    check("midrun reset finished", int'(finished_pool), 0);
    check_zero("midrun reset");
    tick();
    enable = 1'b0;
    reset  = 1'b1;
    tick();
    check("post reset idle finished", int'(finished_pool), 0);
    run_pass(0, 0, edges);
    check("after reset latency", edges, 196);
    check_all("after reset");
    leave_done("after reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
